// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the monitor UART TX and RX blocks.
//   tx_state_e  - 3-bit TX sequencer state encoding
//   DataBits    - number of data bits per frame
//   TmTerminal  - baud timer terminal count (227 clk per bit)
//   calc_parity - parity of a data byte with selectable sense
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam int unsigned DataBits   = 8;
    localparam logic [7:0]  TmTerminal = 8'hE2;

    // odd = 1 inverts the sense so that the data bits plus parity hold an odd count of ones
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// uart_tx_shift: data path of the UART transmitter.
//   clk, rst_x      - clock, asynchronous active-low reset
//   load, load_data - capture a new byte, clear the bit counter, latch its parity
//   shift           - shift right by one and advance the bit counter
//   cur_bit         - bit currently at the LSB (first data bit after a load)
//   next_bit        - bit that becomes the LSB after the next shift
//   last_bit        - bit counter is on the final data bit
//   parity          - parity of the loaded byte
module uart_tx_shift
    import uart_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_x,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] load_data,
    output logic       cur_bit,
    output logic       next_bit,
    output logic       last_bit,
    output logic       parity
);

    localparam logic [2:0] LastCnt = 3'(DataBits - 1);

    logic [7:0] shift_q;
    logic [2:0] cnt_q;
    logic       parity_q;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
        end else if (load) begin
            shift_q  <= load_data;
            cnt_q    <= '0;
            parity_q <= calc_parity(load_data, PARITY_ODD);
        end else if (shift) begin
            shift_q  <= {1'b0, shift_q[7:1]};
            cnt_q    <= cnt_q + 3'd1;
        end
    end

    assign cur_bit  = shift_q[0];
    assign next_bit = shift_q[1];
    assign last_bit = (cnt_q == LastCnt);
    assign parity   = parity_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer with a one-entry holding register.
//   clk, rst_x  - clock, asynchronous active-low reset
//   tx_wr       - one-cycle write strobe, tx_data sampled with it
//   tx_full     - holding register occupied
//   tx_busy     - frame in progress
//   tx_err      - one-cycle pulse after a write that hit a full holding register
//   uart_tm_en  - enable for the shared baud timer (registered)
//   uart_tm_ov  - baud timer overflow strobe, one per bit period
//   txd         - serial output, idle high (registered)
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_x,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_err,
    output logic       uart_tm_en,
    input  logic       uart_tm_ov,
    output logic       txd
);

    localparam logic StopLast = 1'(STOP_BITS - 1);

    tx_state_e  state_q;
    logic       txd_q;
    logic       tm_en_q;
    logic       busy_q;
    logic       stop_cnt_q;

    logic [7:0] hold_q;
    logic       full_q;
    logic       err_q;

    logic       final_stop;
    logic       load;
    logic       shift;
    logic       cur_bit;
    logic       next_bit;
    logic       last_bit;
    logic       parity;

    always_comb begin
        final_stop = (state_q == StStop) && uart_tm_ov && (stop_cnt_q == StopLast);
        load       = full_q && ((state_q == StIdle) || final_stop);
        shift      = (state_q == StData) && uart_tm_ov && !last_bit;
    end

    // A write that finds the register full is dropped even if the register drains on the
    // same edge; the producer must see tx_full low before writing again.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            hold_q <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= tx_wr && full_q;
            if (load) begin
                full_q <= 1'b0;
            end else if (tx_wr && !full_q) begin
                full_q <= 1'b1;
                hold_q <= tx_data;
            end
        end
    end

    uart_tx_shift #(
        .PARITY_ODD (PARITY_ODD)
    ) u_shift (
        .clk       (clk),
        .rst_x     (rst_x),
        .load      (load),
        .shift     (shift),
        .load_data (hold_q),
        .cur_bit   (cur_bit),
        .next_bit  (next_bit),
        .last_bit  (last_bit),
        .parity    (parity)
    );

    // Timer enable stays high from the start bit of one frame through the stop bit of the
    // last queued frame so the bit phase never restarts mid-stream.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q    <= StIdle;
            txd_q      <= 1'b1;
            tm_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (full_q) begin
                        state_q <= StStart;
                        txd_q   <= 1'b0;
                        tm_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (uart_tm_ov) begin
                        state_q <= StData;
                        txd_q   <= cur_bit;
                    end
                end
                StData: begin
                    if (uart_tm_ov) begin
                        if (!last_bit) begin
                            txd_q <= next_bit;
                        end else if (PARITY_EN) begin
                            state_q <= StParity;
                            txd_q   <= parity;
                        end else begin
                            state_q    <= StStop;
                            txd_q      <= 1'b1;
                            stop_cnt_q <= 1'b0;
                        end
                    end
                end
                StParity: begin
                    if (uart_tm_ov) begin
                        state_q    <= StStop;
                        txd_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                    end
                end
                StStop: begin
                    if (uart_tm_ov) begin
                        if (stop_cnt_q != StopLast) begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end else if (full_q) begin
                            state_q <= StStart;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            txd_q   <= 1'b1;
                            tm_en_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    txd_q   <= 1'b1;
                    tm_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_full    = full_q;
    assign tx_busy    = busy_q;
    assign tx_err     = err_q;
    assign uart_tm_en = tm_en_q;
    assign txd        = txd_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl in three configurations
// (8N1, 8E2, 8O1), each paced by its own model of the shared 227-cycle baud timer.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_x;
    logic       wr;
    logic [7:0] wdata;
    logic [1:0] sel;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    logic wr_a, full_a, busy_a, err_a, en_a, ov_a, txd_a;
    logic wr_b, full_b, busy_b, err_b, en_b, ov_b, txd_b;
    logic wr_c, full_c, busy_c, err_c, en_c, ov_c, txd_c;
    logic [7:0] tc_a, tc_b, tc_c;

    assign wr_a = wr && (sel == 2'd0);
    assign wr_b = wr && (sel == 2'd1);
    assign wr_c = wr && (sel == 2'd2);

    // 8N1
    uart_tx_ctrl #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_x(rst_x), .tx_wr(wr_a), .tx_data(wdata), .tx_full(full_a),
        .tx_busy(busy_a), .tx_err(err_a), .uart_tm_en(en_a), .uart_tm_ov(ov_a), .txd(txd_a)
    );
    // 8E2
    uart_tx_ctrl #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_x(rst_x), .tx_wr(wr_b), .tx_data(wdata), .tx_full(full_b),
        .tx_busy(busy_b), .tx_err(err_b), .uart_tm_en(en_b), .uart_tm_ov(ov_b), .txd(txd_b)
    );
    // 8O1
    uart_tx_ctrl #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst_x(rst_x), .tx_wr(wr_c), .tx_data(wdata), .tx_full(full_c),
        .tx_busy(busy_c), .tx_err(err_c), .uart_tm_en(en_c), .uart_tm_ov(ov_c), .txd(txd_c)
    );

    // Baud timer models: count while enabled, strobe at the terminal count, then clear.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            tc_a <= '0;
            tc_b <= '0;
            tc_c <= '0;
        end else begin
            tc_a <= (!en_a || tc_a == TmTerminal) ? 8'd0 : tc_a + 8'd1;
            tc_b <= (!en_b || tc_b == TmTerminal) ? 8'd0 : tc_b + 8'd1;
            tc_c <= (!en_c || tc_c == TmTerminal) ? 8'd0 : tc_c + 8'd1;
        end
    end
    assign ov_a = en_a && (tc_a == TmTerminal);
    assign ov_b = en_b && (tc_b == TmTerminal);
    assign ov_c = en_c && (tc_c == TmTerminal);

    logic mon_txd, mon_en, mon_full, mon_busy, mon_err;
    always_comb begin
        mon_txd  = txd_a;
        mon_en   = en_a;
        mon_full = full_a;
        mon_busy = busy_a;
        mon_err  = err_a;
        case (sel)
            2'd1: begin
                mon_txd = txd_b; mon_en = en_b; mon_full = full_b;
                mon_busy = busy_b; mon_err = err_b;
            end
            2'd2: begin
                mon_txd = txd_c; mon_en = en_c; mon_full = full_c;
                mon_busy = busy_c; mon_err = err_c;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge following the write edge.
    task automatic send(input logic [7:0] b);
        wr    = 1'b1;
        wdata = b;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        while (mon_txd !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_fall"}, mon_txd, 1'b0);
    endtask

    // Starts on the first negedge of the start bit; checks both ends of every bit so each
    // level is pinned to exactly 227 cycles. Optionally queues a byte at the head of bit wr_bit.
    task automatic check_bits(input string tag, input logic [11:0] f, input int n,
                              input int wr_bit, input logic [7:0] wr_byte);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_head%0d", tag, k), mon_txd, f[k]);
            chk($sformatf("%s_en%0d", tag, k), mon_en, 1'b1);
            if (k == wr_bit) begin
                send(wr_byte);
                repeat (225) @(negedge clk);
            end else begin
                repeat (226) @(negedge clk);
            end
            chk($sformatf("%s_tail%0d", tag, k), mon_txd, f[k]);
            chk($sformatf("%s_err%0d", tag, k), mon_err, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_txd"}, mon_txd, 1'b1);
        chk({tag, "_en"}, mon_en, 1'b0);
        chk({tag, "_busy"}, mon_busy, 1'b0);
        chk({tag, "_full"}, mon_full, 1'b0);
    endtask

    initial begin
        int lows;
        rst_x = 1'b0;
        wr    = 1'b0;
        wdata = 8'h00;
        sel   = 2'd0;
        repeat (3) @(negedge clk);
        check_idle("rst");
        chk("rst_err", mon_err, 1'b0);
        rst_x = 1'b1;
        @(negedge clk);

        // Single 8N1 byte 0xA5 with write-to-start latency
        send(8'hA5);
        chk("a5_full_set", mon_full, 1'b1);
        chk("a5_txd_pre", mon_txd, 1'b1);
        @(negedge clk);
        chk("a5_txd_fall", mon_txd, 1'b0);
        chk("a5_full_clr", mon_full, 1'b0);
        chk("a5_busy", mon_busy, 1'b1);
        check_bits("a5", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, -1, 8'h00);
        check_idle("a5_end");

        // Back-to-back 0x00 then 0xFF, second queued during data bit 2
        repeat (5) @(negedge clk);
        send(8'h00);
        wait_fall("bb0");
        check_bits("bb0", {2'b00, 1'b1, 8'h00, 1'b0}, 10, 3, 8'hFF);
        check_bits("bb1", {2'b00, 1'b1, 8'hFF, 1'b0}, 10, -1, 8'h00);
        check_idle("bb_end");

        // Overrun: 0x11 held, 0x22 written on the edge that drains the register
        repeat (5) @(negedge clk);
        send(8'h11);
        chk("ovr_full", mon_full, 1'b1);
        send(8'h22);
        chk("ovr_err_pulse", mon_err, 1'b1);
        chk("ovr_full_clr", mon_full, 1'b0);
        chk("ovr_txd_fall", mon_txd, 1'b0);
        check_bits("ovr", {2'b00, 1'b1, 8'h11, 1'b0}, 10, -1, 8'h00);
        check_idle("ovr_end");
        lows = 0;
        repeat (500) begin
            @(negedge clk);
            if (mon_txd !== 1'b1) lows++;
        end
        chk("ovr_no_second", (lows == 0), 1'b1);

        // Even parity, two stop bits: 0x07 -> parity 1, 0x3C -> parity 0
        sel = 2'd1;
        send(8'h07);
        wait_fall("e07");
        check_bits("e07", {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 12, -1, 8'h00);
        check_idle("e07_end");
        send(8'h3C);
        wait_fall("e3c");
        check_bits("e3c", {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}, 12, -1, 8'h00);
        check_idle("e3c_end");

        // Odd parity, one stop bit: 0x07 -> parity 0, frame 2497 cycles
        sel = 2'd2;
        send(8'h07);
        wait_fall("o07");
        check_bits("o07", {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 8'h00);
        check_idle("o07_end");

        // Reset during data bit 4 of 0x5A with 0xC3 queued
        sel = 2'd0;
        send(8'h5A);
        wait_fall("r5a");
        check_bits("r5a", {2'b00, 1'b1, 8'h5A, 1'b0}, 5, 2, 8'hC3);
        chk("r5a_queued", mon_full, 1'b1);
        repeat (50) @(negedge clk);
        #2 rst_x = 1'b0;
        #1;
        check_idle("rst_mid");
        @(negedge clk);
        rst_x = 1'b1;
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (mon_txd !== 1'b1 || mon_en !== 1'b0) lows++;
        end
        chk("rst_quiet", (lows == 0), 1'b1);
        check_idle("rst_after");

        send(8'h81);
        wait_fall("post");
        check_bits("post", {2'b00, 1'b1, 8'h81, 1'b0}, 10, -1, 8'h00);
        check_idle("post_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit sequencer for the monitor port. It accepts bytes from the monitor core through a one-entry holding register and serialises them onto `txd` as start, data, optional parity and stop bits. It paces every bit by driving the enable of the shared baud-rate timer and consuming that timer's overflow strobe. Together with the timer it forms the TX half of the monitor UART.

## Interface
Parameters:
- PARITY_EN, 0, 1 = append a parity bit after the data bits
- PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 = even, 1 = odd)
- STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
- clk  in  1  clock
- rst_x  in  1  reset, asynchronous, active-low
- tx_wr  in  1  write strobe, one cycle, high active
- tx_data  in  8  byte to send, sampled with tx_wr
- tx_full  out  1  holding register occupied
- tx_busy  out  1  frame in progress (FSM not IDLE)
- tx_err  out  1  one-cycle pulse: tx_wr while tx_full=1
- uart_tm_en  out  1  baud timer enable (registered)
- uart_tm_ov  in  1  baud timer overflow, one-cycle strobe
- txd  out  1  serial output, idle high (registered)

## Operation
- Holding register: tx_wr with tx_full=0 captures tx_data and sets tx_full.
- tx_wr with tx_full=1 is dropped, and tx_err pulses on the next cycle. This holds even if the register empties in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE with tx_full=1: on the next edge, move the holding register into the shift register, clear tx_full, enter START, drive txd=0 and set uart_tm_en=1.
- START: on ov, go to DATA and drive txd = shift[0] (LSB first). A 3-bit counter starts at 0.
- DATA: on each ov, shift right and increment the counter. When ov arrives with count=7, go to PARITY if PARITY_EN=1, else STOP.
- Parity bit = XOR of the 8 data bits, XOR PARITY_ODD. The parity value is computed when the byte loads.
- PARITY: on ov, go to STOP and drive txd=1.
- STOP: drive txd=1 for STOP_BITS bit periods.
- On the final stop ov with tx_full=1: load the next byte, drive txd=0 and go to START. uart_tm_en stays high, giving back-to-back frames with no idle gap.
- On the final stop ov with tx_full=0: go to IDLE with uart_tm_en=0.
- uart_tm_en is high in every state except IDLE. It never drops mid-frame, so the timer phase is continuous across bits.
- A uart_tm_ov seen in IDLE is ignored.

## Timing
- Reset values: txd=1, uart_tm_en=0, tx_full=0, tx_busy=0, tx_err=0, FSM=IDLE, counters=0.
- Timer period is 227 clk cycles per bit (overflow at count 0xE2, then clear).
- Every bit, including the start bit, lasts exactly 227 cycles. txd and uart_tm_en change on the same edge. The first ov appears 226 cycles later and is acted on at the following edge.
- Write-to-start latency from IDLE: tx_wr at edge N gives tx_full=1 after N. At edge N+1, txd falls and tx_full clears.
- Frame length is 227 × (10 + PARITY_EN + STOP_BITS−1) cycles. 8N1 = 2270 cycles.
- tx_full is free again one cycle after a load, so a new byte can be queued during the current frame.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). The held byte is discarded and txd returns high without completing the frame.

## Structure
- Shared package uart_pkg:
  - state encoding constants (3-bit)
  - data bit count (8)
  - timer terminal count 0xE2, so RX and TX share it.
- One natural sub-module, uart_tx_shift:
  - 8-bit shift register plus bit counter and parity generator
  - load/shift controls driven by the FSM.
- The baud timer is instantiated at the UART top level, not inside this block.

## Test plan
- Single 8N1 byte 0xA5 from IDLE -> txd sequence 0,1,0,1,0,0,1,0,1,1. Each level holds 227 cycles. uart_tm_en drops one cycle after the stop ov.
- Two bytes 0x00 then 0xFF, the second written during the first frame's DATA state -> back-to-back frames. txd falls exactly 227 cycles after the first stop bit began. uart_tm_en never drops.
- Write while tx_full=1 (0x11 held, 0x22 written) -> tx_err single pulse. 0x11 is transmitted and 0x22 never appears.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1 after bit 7. With PARITY_ODD=1 the parity bit is 0. Frame = 2497 cycles.
- STOP_BITS=2, byte 0x3C -> stop level held 454 cycles before IDLE.
- rst_x asserted at data bit 4 of 0x5A, with a second byte queued -> txd=1, tx_full=0, uart_tm_en=0 immediately. After release, no transmission until a new tx_wr.
